// File: rtl/ofm_pkg.sv
// Shared types and constants for the MM2S-to-MAC transmit frame manager.
package ofm_pkg;

    localparam logic [3:0] CTRL_TAG_NORMAL = 4'hA;

    localparam int ENTRY_W   = 73;
    localparam int TLAST_BIT = 72;
    localparam int TKEEP_LSB = 64;
    localparam int TDATA_LSB = 0;

    typedef enum logic {
        ST_CTRL = 1'b0,
        ST_DATA = 1'b1
    } ofm_state_e;

    // Field order matches the offsets above: tlast[72], tkeep[71:64], tdata[63:0].
    typedef struct packed {
        logic        tlast;
        logic [7:0]  tkeep;
        logic [63:0] tdata;
    } ofm_entry_t;

endpackage

// File: rtl/ofm_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is readable combinationally.
module ofm_sync_fifo #(
    parameter int WIDTH      = 73,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic             mm2s_clk,
    input  logic             sys_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                wr_fire, rd_fire;

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    always_ff @(posedge mm2s_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge mm2s_clk) begin
        if (wr_fire) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/ofm_fifo.sv
// Transmit frame manager: control packet then one data frame, buffered toward the MAC.
// Define OFM_STORE_FWD_EN to hold output until a whole frame (or a full buffer) is present.
module ofm_fifo
    import ofm_pkg::*;
#(
    parameter int DATA_DEPTH_LOG2 = 9,
    parameter int CTRL_WORDS      = 6
) (
    input  logic                     mm2s_clk,
    input  logic                     sys_rst,
    input  logic [31:0]              txc_tdata,
    input  logic [3:0]               txc_tkeep,
    input  logic                     txc_tlast,
    input  logic                     txc_tvalid,
    output logic                     txc_tready,
    input  logic [63:0]              txd_tdata,
    input  logic [7:0]               txd_tkeep,
    input  logic                     txd_tlast,
    input  logic                     txd_tvalid,
    output logic                     txd_tready,
    output logic [63:0]              tx_axis_tdata,
    output logic [7:0]               tx_axis_tkeep,
    output logic                     tx_axis_tlast,
    output logic                     tx_axis_tvalid,
    input  logic                     tx_axis_tready,
    output logic [DATA_DEPTH_LOG2:0] frames_buffered,
    output logic                     ctrl_err,
    output logic [31:0]              tx_frames
);

    ofm_state_e state, nxt_state;
    ofm_entry_t wr_entry, head;
    logic       rst_q, blocked;
    logic [3:0] word_cnt, tag_q, tag_eff;
    logic       txc_fire, txd_fire, pop, ctrl_bad;
    logic       buf_full, buf_empty, release_ok;
    logic       fb_inc, fb_dec;
    logic       unused_ok;

    assign unused_ok = ^{txc_tkeep, txc_tdata[27:0]};

    // Handshakes stay closed during reset and for one cycle after it.
    assign blocked  = sys_rst | rst_q;
    assign txc_fire = txc_tvalid && txc_tready;
    assign txd_fire = txd_tvalid && txd_tready;

    always_ff @(posedge mm2s_clk) begin
        if (sys_rst) state <= ST_CTRL;
        else         state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            ST_CTRL: if (txc_fire && txc_tlast) nxt_state = ST_DATA;
            ST_DATA: if (txd_fire && txd_tlast) nxt_state = ST_CTRL;
            default: nxt_state = ST_CTRL;
        endcase
    end

    always_comb begin
        txc_tready = 1'b0;
        txd_tready = 1'b0;
        if (!blocked) begin
            case (state)
                ST_CTRL: txc_tready = 1'b1;
                ST_DATA: txd_tready = ~buf_full;
                default: ;
            endcase
        end
    end

    // A one-word packet carries its tag on the tlast beat itself.
    assign tag_eff  = (word_cnt == 4'd0) ? txc_tdata[31:28] : tag_q;
    assign ctrl_bad = (tag_eff != CTRL_TAG_NORMAL) || ((int'(word_cnt) + 1) != CTRL_WORDS);

    always_ff @(posedge mm2s_clk) begin
        if (sys_rst) begin
            rst_q    <= 1'b1;
            word_cnt <= '0;
            tag_q    <= '0;
            ctrl_err <= 1'b0;
        end else begin
            rst_q    <= 1'b0;
            ctrl_err <= 1'b0;
            if (txc_fire) begin
                if (word_cnt == 4'd0) tag_q <= txc_tdata[31:28];
                if (txc_tlast) begin
                    word_cnt <= '0;
                    ctrl_err <= ctrl_bad;
                end else if (word_cnt != 4'hF) begin
                    word_cnt <= word_cnt + 4'd1;
                end
            end
        end
    end

    assign wr_entry = '{tlast: txd_tlast, tkeep: txd_tkeep, tdata: txd_tdata};

    ofm_sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DATA_DEPTH_LOG2)
    ) u_buf (
        .mm2s_clk (mm2s_clk),
        .sys_rst  (sys_rst),
        .wr_en    (txd_fire),
        .wr_data  (wr_entry),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (buf_full),
        .empty    (buf_empty)
    );

`ifdef OFM_STORE_FWD_EN
    // Full-buffer term lets oversize frames drain cut-through instead of deadlocking.
    assign release_ok = (frames_buffered != '0) || buf_full;
`else
    assign release_ok = 1'b1;
`endif

    assign tx_axis_tvalid = ~buf_empty && release_ok && ~blocked;
    assign pop            = tx_axis_tvalid && tx_axis_tready;
    assign tx_axis_tdata  = tx_axis_tvalid ? head.tdata : '0;
    assign tx_axis_tkeep  = tx_axis_tvalid ? head.tkeep : '0;
    assign tx_axis_tlast  = tx_axis_tvalid ? head.tlast : 1'b0;

    assign fb_inc = txd_fire && txd_tlast;
    assign fb_dec = pop && head.tlast;

    always_ff @(posedge mm2s_clk) begin
        if (sys_rst) begin
            frames_buffered <= '0;
            tx_frames       <= '0;
        end else begin
            case ({fb_inc, fb_dec})
                2'b10:   frames_buffered <= frames_buffered + 1'b1;
                2'b01:   frames_buffered <= frames_buffered - 1'b1;
                default: ;
            endcase
            if (fb_dec) tx_frames <= tx_frames + 32'd1;
        end
    end

endmodule

// File: tb/tb_ofm_fifo.sv
// Scoreboard bench for ofm_fifo: driver queues expected MAC beats, monitor pops and compares.
module tb_ofm_fifo;

    localparam int DL2 = 4;
`ifdef OFM_STORE_FWD_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    logic          mm2s_clk = 1'b0;
    logic          sys_rst;
    logic [31:0]   txc_tdata;
    logic [3:0]    txc_tkeep;
    logic          txc_tlast, txc_tvalid, txc_tready;
    logic [63:0]   txd_tdata;
    logic [7:0]    txd_tkeep;
    logic          txd_tlast, txd_tvalid, txd_tready;
    logic [63:0]   tx_axis_tdata;
    logic [7:0]    tx_axis_tkeep;
    logic          tx_axis_tlast, tx_axis_tvalid, tx_axis_tready;
    logic [DL2:0]  frames_buffered;
    logic          ctrl_err;
    logic [31:0]   tx_frames;

    int            checks = 0;
    int            fails  = 0;
    logic [72:0]   exp_q[$];
    int            err_pulses = 0;
    int            err_long   = 0;
    logic          err_prev   = 1'b0;
    logic          hold_v     = 1'b0;
    logic [72:0]   hold_e;

    always #5 mm2s_clk = ~mm2s_clk;

    ofm_fifo #(.DATA_DEPTH_LOG2(DL2), .CTRL_WORDS(6)) dut (
        .mm2s_clk(mm2s_clk), .sys_rst(sys_rst),
        .txc_tdata(txc_tdata), .txc_tkeep(txc_tkeep), .txc_tlast(txc_tlast),
        .txc_tvalid(txc_tvalid), .txc_tready(txc_tready),
        .txd_tdata(txd_tdata), .txd_tkeep(txd_tkeep), .txd_tlast(txd_tlast),
        .txd_tvalid(txd_tvalid), .txd_tready(txd_tready),
        .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
        .tx_axis_tlast(tx_axis_tlast), .tx_axis_tvalid(tx_axis_tvalid),
        .tx_axis_tready(tx_axis_tready),
        .frames_buffered(frames_buffered), .ctrl_err(ctrl_err), .tx_frames(tx_frames)
    );

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every MAC handshake against the queue and checks hold stability.
    always @(negedge mm2s_clk) begin
        logic [72:0] cur;
        logic [72:0] e;
        cur = {tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata};
        if (sys_rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", tx_axis_tvalid, 1);
                chk("hold_data", cur, hold_e);
            end
            if (tx_axis_tvalid && tx_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", cur, e);
                end
            end
            hold_v = tx_axis_tvalid && !tx_axis_tready;
            hold_e = cur;
        end
        if (ctrl_err === 1'b1) err_pulses++;
        if (ctrl_err === 1'b1 && err_prev) err_long++;
        err_prev = (ctrl_err === 1'b1);
    end

    task automatic send_c(input int n, input logic [31:0] w0);
        for (int i = 0; i < n; i++) begin
            logic hs;
            txc_tdata  = (i == 0) ? w0 : 32'h0000_1000 + i;
            txc_tlast  = (i == n - 1);
            txc_tvalid = 1'b1;
            hs = 1'b0;
            for (int t = 0; t < 300 && !hs; t++) begin
                @(negedge mm2s_clk);
                hs = txc_tready;
                @(posedge mm2s_clk); #1;
            end
            if (!hs) begin
                checks++; fails++;
                $display("FAIL txc_timeout: got ready=0 expected ready=1");
            end
        end
        txc_tvalid = 1'b0;
        txc_tlast  = 1'b0;
    endtask

    task automatic send_d(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic hs;
        txd_tdata  = d;
        txd_tkeep  = k;
        txd_tlast  = l;
        txd_tvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 300 && !hs; t++) begin
            @(negedge mm2s_clk);
            hs = txd_tready;
            if (hs) exp_q.push_back({l, k, d});
            @(posedge mm2s_clk); #1;
        end
        txd_tvalid = 1'b0;
        txd_tlast  = 1'b0;
        if (!hs) begin
            checks++; fails++;
            $display("FAIL txd_timeout: got ready=0 expected ready=1");
        end
    endtask

    task automatic send_frame(input int nb, input logic [63:0] base);
        for (int i = 0; i < nb; i++)
            send_d(base + 64'(i), 8'hFF, i == nb - 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 600 && (exp_q.size() != 0 || tx_axis_tvalid); t++) begin
            @(posedge mm2s_clk); #1;
        end
        chk("drain_done", exp_q.size() == 0, 1);
        @(posedge mm2s_clk); #1;
    endtask

    initial begin
        sys_rst = 1'b1;
        txc_tdata = '0; txc_tkeep = 4'hF; txc_tlast = 1'b0; txc_tvalid = 1'b0;
        txd_tdata = '0; txd_tkeep = '0;   txd_tlast = 1'b0; txd_tvalid = 1'b0;
        tx_axis_tready = 1'b1;

        // Reset state, during and the first cycle after reset
        repeat (3) @(posedge mm2s_clk);
        @(negedge mm2s_clk);
        chk("rst_txc_tready", txc_tready, 0);
        chk("rst_txd_tready", txd_tready, 0);
        chk("rst_tvalid", tx_axis_tvalid, 0);
        chk("rst_ctrl_err", ctrl_err, 0);
        @(posedge mm2s_clk); #1;
        sys_rst = 1'b0;
        @(negedge mm2s_clk);
        chk("post_rst_txc_tready", txc_tready, 0);
        chk("post_rst_frames_buf", frames_buffered, 0);
        chk("post_rst_tx_frames", tx_frames, 0);
        chk("post_rst_out", {tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata}, 0);
        @(posedge mm2s_clk); #1;

        // Good control packet, 3-beat frame with partial last keep
        send_c(6, 32'hA000_0000);
        send_d(64'h0011_2233_4455_6677, 8'hFF, 1'b0);
        chk("t1_first_beat_valid", tx_axis_tvalid, !SF);
        send_d(64'h8899_AABB_CCDD_EEFF, 8'hFF, 1'b0);
        send_d(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1);
        chk("t1_last_beat_valid", tx_axis_tvalid, 1);
        drain();
        chk("t1_tx_frames", tx_frames, 1);
        chk("t1_frames_buf", frames_buffered, 0);
        chk("t1_no_err", err_pulses, 0);

        // Short control packet, then bad tag; frames still flow
        send_c(5, 32'hA000_0000);
        chk("t2_err_now", ctrl_err, 1);
        send_frame(2, 64'h2000);
        drain();
        chk("t2_err_count", err_pulses, 1);
        send_c(6, 32'hB000_0000);
        send_frame(1, 64'h2100);
        drain();
        chk("t2_err_count2", err_pulses, 2);
        chk("t2_err_single", err_long, 0);
        chk("t2_tx_frames", tx_frames, 3);

        // 8-beat frame release latency
        send_c(6, 32'hA123_4567);
        for (int i = 0; i < 8; i++) begin
            send_d(64'h3000 + 64'(i), 8'hFF, i == 7);
            if (i < 7) chk("t3_valid_mid", tx_axis_tvalid, !SF);
            else       chk("t3_valid_after_last", tx_axis_tvalid, 1);
        end
        drain();
        chk("t3_tx_frames", tx_frames, 4);

        // 40-beat frame through a 16-entry buffer
        send_c(6, 32'hA000_0000);
        send_frame(40, 64'h4000);
        drain();
        chk("t4_tx_frames", tx_frames, 5);
        chk("t4_frames_buf", frames_buffered, 0);

        // MAC stalls for 20 cycles mid-frame
        tx_axis_tready = 1'b0;
        send_c(6, 32'hA000_0000);
        fork
            send_frame(24, 64'h5000);
            begin
                repeat (20) @(posedge mm2s_clk);
                @(negedge mm2s_clk);
                chk("t5_txd_stalled", txd_tready, 0);
                chk("t5_frames_buf", frames_buffered, 0);
                @(posedge mm2s_clk); #1;
                tx_axis_tready = 1'b1;
            end
        join
        drain();
        chk("t5_tx_frames", tx_frames, 6);

        // Reset during beat 2 of a frame
        tx_axis_tready = 1'b0;
        send_c(6, 32'hA000_0000);
        send_d(64'h6000, 8'hFF, 1'b0);
        txd_tdata = 64'h6001; txd_tkeep = 8'hFF; txd_tvalid = 1'b1;
        sys_rst = 1'b1;
        @(negedge mm2s_clk);
        chk("t6_rst_txd_tready", txd_tready, 0);
        chk("t6_rst_tvalid", tx_axis_tvalid, 0);
        chk("t6_rst_tdata", tx_axis_tdata, 0);
        @(posedge mm2s_clk); #1;
        sys_rst = 1'b0;
        txd_tvalid = 1'b0;
        exp_q.delete();
        @(negedge mm2s_clk);
        chk("t6_post_txc_tready", txc_tready, 0);
        chk("t6_post_tvalid", tx_axis_tvalid, 0);
        chk("t6_post_frames_buf", frames_buffered, 0);
        chk("t6_post_tx_frames", tx_frames, 0);
        @(posedge mm2s_clk); #1;
        @(negedge mm2s_clk);
        chk("t6_ctrl_ready", txc_tready, 1);
        @(posedge mm2s_clk); #1;
        tx_axis_tready = 1'b1;
        send_c(6, 32'hA000_0000);
        send_frame(2, 64'h7000);
        drain();
        chk("t6_tx_frames", tx_frames, 1);
        chk("t6_frames_buf", frames_buffered, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
